// File: rtl/fht_pkg.sv
// Shared constants, state encoding and rounding helper for the FHT write-back stage.
package fht_pkg;

  localparam int unsigned FHT_D_BIT = 17;
  localparam int unsigned FHT_A_BIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } wb_state_e;

  localparam logic signed [FHT_D_BIT-1:0] Y_MAX = {1'b0, {(FHT_D_BIT-1){1'b1}}};
  localparam logic signed [FHT_D_BIT-1:0] Y_MIN = {1'b1, {(FHT_D_BIT-1){1'b0}}};

  // (y+1)>>>1 in one extra bit, so the most positive input cannot wrap.
  function automatic logic signed [FHT_D_BIT-1:0] halve_round(
    input logic signed [FHT_D_BIT-1:0] y
  );
    logic signed [FHT_D_BIT:0] t;
    t = {y[FHT_D_BIT-1], y} + (FHT_D_BIT+1)'(1);
    return t[FHT_D_BIT:1];
  endfunction

endpackage

// File: rtl/fht_wb_delay.sv
// LAT-deep shift register of {valid, addr, scale} aligning read addresses with butterfly results.
module fht_wb_delay #(
  parameter int unsigned LAT   = 3,
  parameter int unsigned A_BIT = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vld_i,
  input  logic [A_BIT-1:0] addr_i,
  input  logic             scale_i,
  output logic             vld_o,
  output logic [A_BIT-1:0] addr_o,
  output logic             scale_o,
  output logic             any_vld_o
);

  logic [LAT-1:0]   vld_q;
  logic [LAT-1:0]   scl_q;
  logic [A_BIT-1:0] addr_q [LAT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      scl_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) addr_q[i] <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      scl_q[0]  <= scale_i;
      addr_q[0] <= addr_i;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        scl_q[i]  <= scl_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign vld_o     = vld_q[LAT-1];
  assign scale_o   = scl_q[LAT-1];
  assign addr_o    = addr_q[LAT-1];
  assign any_vld_o = |vld_q;

endmodule

// File: rtl/fht_wr_back.sv
// Write-back stage: delays read addresses to meet butterfly results, optionally halves them,
// writes all four banks at one address and signals stage completion.
module fht_wr_back
  import fht_pkg::*;
#(
  parameter int unsigned D_BIT = FHT_D_BIT,
  parameter int unsigned A_BIT = FHT_A_BIT,
  parameter int unsigned LAT   = 3
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iRD_VALID,
  input  logic [A_BIT-1:0]        iRD_ADDR,
  input  logic                    iSCALE,
  input  logic                    iSTAGE_END,
  input  logic                    iCLR_OVF,
  input  logic signed [D_BIT-1:0] iY_0,
  input  logic signed [D_BIT-1:0] iY_1,
  input  logic signed [D_BIT-1:0] iY_2,
  input  logic signed [D_BIT-1:0] iY_3,
  output logic                    oWR_EN,
  output logic [A_BIT-1:0]        oWR_ADDR,
  output logic signed [D_BIT-1:0] oWR_DATA_0,
  output logic signed [D_BIT-1:0] oWR_DATA_1,
  output logic signed [D_BIT-1:0] oWR_DATA_2,
  output logic signed [D_BIT-1:0] oWR_DATA_3,
  output logic                    oBUSY,
  output logic                    oDONE,
  output logic                    oOVF
);

  localparam int unsigned           CNT_W    = $clog2(LAT + 2);
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(LAT + 1);

  wb_state_e              state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   ovf_q;
  logic                   wr_en_q;
  logic [A_BIT-1:0]       wr_addr_q;
  logic signed [D_BIT-1:0] wr_data_q [4];
  logic signed [D_BIT-1:0] wr_data_d [4];
  logic signed [D_BIT-1:0] y [4];

  logic                   rd_accept;
  logic                   tail_vld;
  logic [A_BIT-1:0]       tail_addr;
  logic                   tail_scl;
  logic                   any_vld;
  logic                   ext_hit;

  // Reads arriving after the stage has ended never enter the pipeline.
  assign rd_accept = iRD_VALID && (state_q == ST_IDLE || state_q == ST_RUN);

  fht_wb_delay #(
    .LAT   (LAT),
    .A_BIT (A_BIT)
  ) u_delay (
    .clk_i     (iCLK),
    .rst_i     (iRESET),
    .vld_i     (rd_accept),
    .addr_i    (iRD_ADDR),
    .scale_i   (iSCALE),
    .vld_o     (tail_vld),
    .addr_o    (tail_addr),
    .scale_o   (tail_scl),
    .any_vld_o (any_vld)
  );

  assign y[0] = iY_0;
  assign y[1] = iY_1;
  assign y[2] = iY_2;
  assign y[3] = iY_3;

  always_comb begin
    ext_hit = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      wr_data_d[k] = tail_scl ? halve_round(y[k]) : y[k];
      if (y[k] == Y_MAX || y[k] == Y_MIN) ext_hit = 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      for (int unsigned k = 0; k < 4; k++) wr_data_q[k] <= '0;
    end else begin
      wr_en_q <= tail_vld;
      if (tail_vld) begin
        wr_addr_q <= tail_addr;
        for (int unsigned k = 0; k < 4; k++) wr_data_q[k] <= wr_data_d[k];
      end

      if (tail_vld && !tail_scl && ext_hit) ovf_q <= 1'b1;
      else if (iCLR_OVF)                    ovf_q <= 1'b0;

      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (iSTAGE_END && iRD_VALID) begin
            state_q <= ST_DRAIN;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
          end else if (iSTAGE_END) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b1;
          end else if (iRD_VALID) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (iSTAGE_END) begin
            state_q <= ST_DRAIN;
            cnt_q   <= CNT_LOAD;
          end
        end
        ST_DRAIN: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          // Leave when the count is reaching zero this cycle, so oDONE follows the last write by one cycle.
          if (cnt_q <= CNT_W'(1) && !any_vld) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oWR_EN     = wr_en_q;
  assign oWR_ADDR   = wr_addr_q;
  assign oWR_DATA_0 = wr_data_q[0];
  assign oWR_DATA_1 = wr_data_q[1];
  assign oWR_DATA_2 = wr_data_q[2];
  assign oWR_DATA_3 = wr_data_q[3];
  assign oBUSY      = busy_q;
  assign oDONE      = done_q;
  assign oOVF       = ovf_q;

endmodule
